// File: rtl/loopback_fifo.sv
// Full-duplex UART loopback: RX and TX state machines decoupled by a
// DEPTH-entry FIFO, with a per-word transform applied before queuing.
module loopback_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              rx_ready,
    output logic              r_valid,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] r_data,
    input  logic              tx_ready,
    output logic              t_valid,
    output logic [DATA_W-1:0] t_data,
    input  logic              tx_done,
    output logic [AW:0]       level,
    output logic              err
);

    typedef enum logic {R_IDLE, R_WAIT} rx_state_e;
    typedef enum logic {T_IDLE, T_WAIT} tx_state_e;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    rx_state_e         rx_state_q, rx_state_d;
    tx_state_e         tx_state_q, tx_state_d;
    logic              r_valid_q, r_valid_d;
    logic              t_valid_q, t_valid_d;
    logic [DATA_W-1:0] t_data_q, t_data_d;
    logic [AW:0]       level_q, level_d;
    logic              err_q, err_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push, pop;
    logic [DATA_W-1:0] push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= R_IDLE;
            tx_state_q <= T_IDLE;
            r_valid_q  <= 1'b0;
            t_valid_q  <= 1'b0;
            t_data_q   <= '0;
            level_q    <= '0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            r_valid_q  <= r_valid_d;
            t_valid_q  <= t_valid_d;
            t_data_q   <= t_data_d;
            level_q    <= level_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            R_IDLE:  if (rx_ready && level_q < LVL_FULL) rx_state_d = R_WAIT;
            R_WAIT:  if (rx_done) rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            T_IDLE:  if (tx_ready && level_q != '0) tx_state_d = T_WAIT;
            T_WAIT:  if (tx_done) tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_comb begin
        case (mode)
            2'd1:    push_data = r_data + DATA_W'(1);
            2'd2:    push_data = ~r_data;
            default: push_data = r_data;
        endcase
        // Arming only with free space means a push can never overflow.
        r_valid_d = (rx_state_q == R_IDLE) && rx_ready && (level_q < LVL_FULL);
        push      = (rx_state_q == R_WAIT) && rx_done && (mode != 2'd3);
        pop       = (tx_state_q == T_IDLE) && tx_ready && (level_q != '0);
        t_valid_d = pop;
        t_data_d  = pop ? mem_q[rd_ptr_q] : t_data_q;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
        err_d     = err_q
                  | (rx_done && rx_state_q == R_IDLE)
                  | (tx_done && tx_state_q == T_IDLE);
    end

    assign r_valid = r_valid_q;
    assign t_valid = t_valid_q;
    assign t_data  = t_data_q;
    assign level   = level_q;
    assign err     = err_q;

endmodule

// File: tb/tb_loopback_fifo.sv
// Directed bench for loopback_fifo: echo, transforms, back-pressure,
// wrap ordering, protocol errors and mid-operation reset.
module tb_loopback_fifo;

    logic       clk = 1'b0;
    logic       rst, rx_ready, rx_done, tx_ready, tx_done;
    logic [1:0] mode;
    logic [7:0] r_data, t_data;
    logic       r_valid, t_valid, err;
    logic [4:0] level;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    loopback_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .rx_ready(rx_ready), .r_valid(r_valid), .rx_done(rx_done), .r_data(r_data),
        .tx_ready(tx_ready), .t_valid(t_valid), .t_data(t_data), .tx_done(tx_done),
        .level(level), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input string tag);
        rx_ready = 1'b1;
        tick();
        chk({tag, "_rvalid"}, 32'(r_valid), 32'd1);
        rx_ready = 1'b0;
    endtask

    task automatic deliver(input logic [7:0] d);
        r_data  = d;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Waits (bounded) for a launch, checks the word, then ends the frame.
    task automatic launch_chk(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!t_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_tvalid"}, 32'(t_valid), 32'd1);
        chk({tag, "_tdata"}, 32'(t_data), 32'(exp));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1; rx_ready = 1'b0; rx_done = 1'b0; tx_ready = 1'b0;
        tx_done = 1'b0; mode = 2'd0; r_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rvalid", 32'(r_valid), 32'd0);
        chk("rst_tvalid", 32'(t_valid), 32'd0);
        chk("rst_tdata",  32'(t_data),  32'd0);
        chk("rst_level",  32'(level),   32'd0);
        chk("rst_err",    32'(err),     32'd0);

        // Echo: launch one cycle after the push edge
        tx_ready = 1'b1;
        arm("echo");
        deliver(8'h41);
        chk("echo_level1", 32'(level), 32'd1);
        chk("echo_tv_early", 32'(t_valid), 32'd0);
        tick();
        chk("echo_tv", 32'(t_valid), 32'd1);
        chk("echo_tdata", 32'(t_data), 32'h41);
        chk("echo_level0", 32'(level), 32'd0);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        chk("echo_err", 32'(err), 32'd0);

        // Transforms
        mode = 2'd1; arm("inc"); deliver(8'hFF); launch_chk("inc", 8'h00);
        mode = 2'd2; arm("inv"); deliver(8'h5A); launch_chk("inv", 8'hA5);
        mode = 2'd3; arm("drop"); deliver(8'h33);
        chk("drop_level", 32'(level), 32'd0);
        tick();
        chk("drop_tvalid", 32'(t_valid), 32'd0);
        chk("drop_level2", 32'(level), 32'd0);
        mode = 2'd0;

        // Fill with TX blocked, then check arming is held off
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            arm("fill");
            deliver(8'(i));
            chk("fill_level", 32'(level), 32'(i + 1));
        end
        rx_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (r_valid) pulses++;
        end
        chk("full_no_arm", 32'(pulses), 32'd0);
        tx_ready = 1'b1;
        tick();
        chk("drain_tvalid", 32'(t_valid), 32'd1);
        chk("drain_first", 32'(t_data), 32'h00);
        chk("drain_level", 32'(level), 32'd15);
        chk("drain_no_arm_yet", 32'(r_valid), 32'd0);
        tick();
        chk("drain_rearm", 32'(r_valid), 32'd1);
        rx_ready = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        for (int i = 1; i < 16; i++) launch_chk("drain", 8'(i));
        chk("drain_empty", 32'(level), 32'd0);

        // RX is already armed: build level 3, then push and pop together
        tx_ready = 1'b0;
        deliver(8'h20);
        arm("pp"); deliver(8'h21);
        arm("pp"); deliver(8'h22);
        chk("pp_level3", 32'(level), 32'd3);
        arm("pp");
        tx_ready = 1'b1; r_data = 8'h23; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("pp_level", 32'(level), 32'd3);
        chk("pp_tvalid", 32'(t_valid), 32'd1);
        chk("pp_tdata", 32'(t_data), 32'h20);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        launch_chk("pp", 8'h21);
        launch_chk("pp", 8'h22);
        launch_chk("pp", 8'h23);

        // 40 words in batches of 8, crossing the pointer wrap
        for (int b = 0; b < 5; b++) begin
            tx_ready = 1'b0;
            for (int i = 0; i < 8; i++) begin
                arm("wrap");
                deliver(8'(8'h80 + b * 8 + i));
            end
            chk("wrap_level", 32'(level), 32'd8);
            tx_ready = 1'b1;
            for (int i = 0; i < 8; i++) launch_chk("wrap", 8'(8'h80 + b * 8 + i));
        end
        chk("wrap_empty", 32'(level), 32'd0);

        // Stray completion pulses
        chk("err_before", 32'(err), 32'd0);
        r_data = 8'h55; rx_done = 1'b1; tick(); rx_done = 1'b0;
        chk("err_rx", 32'(err), 32'd1);
        chk("err_rx_level", 32'(level), 32'd0);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        chk("err_tx_level", 32'(level), 32'd0);
        tick(); tick();
        chk("err_sticky", 32'(err), 32'd1);

        // Reset with level 5 and TX mid-frame
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            arm("mid");
            deliver(8'(8'hC0 + i));
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("mid_tvalid", 32'(t_valid), 32'd1);
        chk("mid_level", 32'(level), 32'd5);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_level",  32'(level),   32'd0);
        chk("mid_rst_tvalid", 32'(t_valid), 32'd0);
        chk("mid_rst_tdata",  32'(t_data),  32'd0);
        chk("mid_rst_err",    32'(err),     32'd0);
        chk("mid_rst_rvalid", 32'(r_valid), 32'd0);
        tx_ready = 1'b1;
        arm("post");
        deliver(8'h7E);
        chk("post_level1", 32'(level), 32'd1);
        tick();
        chk("post_tvalid", 32'(t_valid), 32'd1);
        chk("post_tdata", 32'(t_data), 32'h7E);
        chk("post_level0", 32'(level), 32'd0);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        chk("post_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
